// File: rtl/wb_periph_splitter.sv
// Wishbone splitter: fans the user-project port out to NUM_SLAVES peripheral windows,
// with a bus-timeout watchdog, error acks for unmapped windows, local CSRs and IRQ routing.
module wb_periph_splitter #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]      s_irq_i,
    output logic [2:0]                 user_irq
);

    localparam int unsigned CW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  LOCAL_IDX = 4'hF;
    localparam logic [31:0] UNMAP_DAT = 32'hDEAD_BEEF;
    localparam logic [31:0] TOUT_DAT  = 32'hBADC_0FFE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_TOUT,
        S_DRAIN
    } state_e;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    abort_q;
    logic [31:0]             rdata_q;
    logic [15:0]             err_cnt_q;
    logic                    to_flag_q;
    logic [31:0]             last_err_q;
    logic [NUM_SLAVES-1:0]   mask_q;
    logic [2:0]              irq_q;

    logic [3:0]              idx;
    logic                    req;
    logic                    slave_hit;
    logic                    local_hit;
    logic                    bus_phase;
    logic                    resp_phase;
    logic                    sel_ack;
    logic [31:0]             sel_dat;
    logic                    fwd_ack;
    logic [31:0]             csr_rdata;
    logic                    csr_wr;
    logic [15:0]             err_cnt_inc;
    logic [CW-1:0]           cnt_inc;
    logic [2:0]              irq_d;

    assign idx         = wbs_adr_i[19:16];
    assign req         = wbs_stb_i & wbs_cyc_i;
    assign slave_hit   = (32'(idx) < NUM_SLAVES);
    assign local_hit   = (idx == LOCAL_IDX);
    assign bus_phase   = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign resp_phase  = (state_q == S_RESP) || (state_q == S_TOUT);
    assign csr_wr      = wbs_we_i && (wbs_sel_i == 4'hF);
    assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
    assign cnt_inc     = cnt_q + CW'(1);

    // Select the addressed slave's ack and read data
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == 4'(i)) begin
                sel_ack = s_ack_i[i];
                sel_dat = s_dat_i[32*i +: 32];
            end
        end
    end

    // Per-slave strobe: only while a slave access can be in flight and not aborted
    always_comb begin
        s_stb_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_stb_o[i] = wb_rst_n_i & bus_phase & ~abort_q & wbs_stb_i & (idx == 4'(i));
        end
    end

    assign fwd_ack   = bus_phase & req & slave_hit & sel_ack;
    assign wbs_ack_o = wb_rst_n_i & (fwd_ack | resp_phase);
    assign wbs_dat_o = resp_phase ? rdata_q : sel_dat;
    assign user_irq  = irq_q;

    // Local CSR read mux
    always_comb begin
        case (wbs_adr_i[3:2])
            2'd0:    csr_rdata = {15'd0, to_flag_q, err_cnt_q};
            2'd1:    csr_rdata = 32'(mask_q);
            2'd2:    csr_rdata = last_err_q;
            default: csr_rdata = '0;
        endcase
    end

    // Masked interrupts folded onto three lines by slave index modulo 3
    always_comb begin
        irq_d = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            irq_d[i % 3] = irq_d[i % 3] | (s_irq_i[i] & mask_q[i]);
        end
    end

    // Transaction FSM, watchdog, CSRs and registered IRQ outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            rdata_q    <= '0;
            err_cnt_q  <= '0;
            to_flag_q  <= 1'b0;
            last_err_q <= '0;
            mask_q     <= '0;
            irq_q      <= '0;
        end else begin
            irq_q <= irq_d;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (req) begin
                        if (slave_hit) begin
                            // A same-cycle slave ack completes the access here
                            if (!sel_ack) state_q <= S_WAIT;
                        end else if (local_hit) begin
                            rdata_q <= csr_rdata;
                            state_q <= S_RESP;
                            if (csr_wr) begin
                                case (wbs_adr_i[3:2])
                                    2'd0: begin
                                        err_cnt_q <= '0;
                                        to_flag_q <= 1'b0;
                                    end
                                    2'd1:    mask_q <= wbs_dat_i[NUM_SLAVES-1:0];
                                    default: ;
                                endcase
                            end
                        end else begin
                            rdata_q    <= UNMAP_DAT;
                            err_cnt_q  <= err_cnt_inc;
                            last_err_q <= wbs_adr_i;
                            state_q    <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (req && sel_ack) begin
                        state_q <= S_IDLE;
                    end else if (!req) begin
                        state_q <= S_IDLE;
                    end else if (cnt_inc == CW'(TIMEOUT)) begin
                        state_q    <= S_TOUT;
                        abort_q    <= 1'b1;
                        rdata_q    <= TOUT_DAT;
                        err_cnt_q  <= err_cnt_inc;
                        last_err_q <= wbs_adr_i;
                        to_flag_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                S_TOUT:  state_q <= S_DRAIN;
                S_DRAIN: begin
                    if (!wbs_stb_i) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_periph_splitter.sv
// Directed bench for wb_periph_splitter with four slaves and an 8-cycle timeout.
module tb_wb_periph_splitter;

    localparam int unsigned NS = 4;
    localparam int unsigned TO = 8;

    localparam logic [31:0] A_STATUS = 32'h300F_0000;
    localparam logic [31:0] A_MASK   = 32'h300F_0004;
    localparam logic [31:0] A_LAST   = 32'h300F_0008;

    logic            clk;
    logic            rst_n;
    logic            stb, cyc, we;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat;
    logic            ack;
    logic [31:0]     rdat;
    logic [NS-1:0]   s_stb;
    logic [NS-1:0]   s_ack;
    logic [32*NS-1:0] s_dat;
    logic [NS-1:0]   s_irq;
    logic [2:0]      uirq;

    int n_tests = 0;
    int n_fail  = 0;

    wb_periph_splitter #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .s_stb_o    (s_stb),
        .s_ack_i    (s_ack),
        .s_dat_i    (s_dat),
        .s_irq_i    (s_irq),
        .user_irq   (uirq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        stb   = 1'b0;
        cyc   = 1'b0;
        we    = 1'b0;
        sel   = 4'hF;
        s_ack = '0;
    endtask

    // Local/unmapped access: no ack in the request cycle, one ack cycle, then none
    task automatic reg_op(input string tag, input logic [31:0] a, input logic w,
                          input logic [3:0] s, input logic [31:0] d,
                          input logic [31:0] exp_rd, input bit check_rd);
        adr  = a;
        we   = w;
        sel  = s;
        wdat = d;
        stb  = 1'b1;
        cyc  = 1'b1;
        #1;
        chk({tag, "_ack_early"}, 32'(ack), 32'd0);
        @(negedge clk);
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        if (check_rd) chk({tag, "_data"}, rdat, exp_rd);
        bus_idle();
        @(negedge clk);
        chk({tag, "_ack_after"}, 32'(ack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus_idle();
        adr   = 32'h3000_0000;
        wdat  = '0;
        s_irq = '0;
        s_dat[0*32 +: 32] = 32'h0BAD_F00D;
        s_dat[1*32 +: 32] = 32'h1234_5678;
        s_dat[2*32 +: 32] = 32'h2222_2222;
        s_dat[3*32 +: 32] = 32'h3333_3333;

        // Reset held with a live request: nothing may escape
        stb = 1'b1;
        cyc = 1'b1;
        s_ack = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_stb", 32'(s_stb), 32'd0);
        chk("rst_irq", 32'(uirq), 32'd0);
        bus_idle();
        rst_n = 1'b1;
        @(negedge clk);

        // Slave path, zero-latency ack
        adr   = 32'h3001_0004;
        stb   = 1'b1;
        cyc   = 1'b1;
        s_ack = 4'b0010;
        #1;
        chk("slv_ack", 32'(ack), 32'd1);
        chk("slv_dat", rdat, 32'h1234_5678);
        chk("slv_stb", 32'(s_stb), 32'h2);
        bus_idle();
        @(negedge clk);

        // Unmapped window and error bookkeeping
        reg_op("unmap", 32'h3007_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
        reg_op("status1", A_STATUS, 1'b0, 4'hF, 32'h0, 32'h0000_0001, 1'b1);
        reg_op("last1", A_LAST, 1'b0, 4'hF, 32'h0, 32'h3007_0000, 1'b1);
        reg_op("clr1", A_STATUS, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0);
        reg_op("status_clr1", A_STATUS, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);

        // Timeout: silent slave 2, ack in cycle TO+1
        adr = 32'h3002_0000;
        stb = 1'b1;
        cyc = 1'b1;
        #1;
        for (int c = 0; c <= TO + 1; c++) begin
            if (c > 0) @(negedge clk);
            if (c <= TO) begin
                chk($sformatf("to_wait_ack_c%0d", c), 32'(ack), 32'd0);
                chk($sformatf("to_wait_stb_c%0d", c), 32'(s_stb), 32'h4);
            end else begin
                chk("to_ack", 32'(ack), 32'd1);
                chk("to_dat", rdat, 32'hBADC_0FFE);
                chk("to_stb", 32'(s_stb), 32'd0);
            end
        end
        @(negedge clk);
        s_ack = 4'b0100;
        #1;
        chk("drain_ack", 32'(ack), 32'd0);
        chk("drain_stb", 32'(s_stb), 32'd0);
        bus_idle();
        @(negedge clk);
        reg_op("status_to", A_STATUS, 1'b0, 4'hF, 32'h0, 32'h0001_0001, 1'b1);
        reg_op("last_to", A_LAST, 1'b0, 4'hF, 32'h0, 32'h3002_0000, 1'b1);
        reg_op("clr2", A_STATUS, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        reg_op("status_clr2", A_STATUS, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);

        // Slave ack in the last cycle before the watchdog fires wins
        adr = 32'h3003_0000;
        stb = 1'b1;
        cyc = 1'b1;
        for (int c = 0; c < TO; c++) @(negedge clk);
        s_dat[3*32 +: 32] = 32'hCAFE_F00D;
        s_ack = 4'b1000;
        #1;
        chk("bnd_ack", 32'(ack), 32'd1);
        chk("bnd_dat", rdat, 32'hCAFE_F00D);
        bus_idle();
        @(negedge clk);
        chk("bnd_no_tout", 32'(ack), 32'd0);
        reg_op("status_bnd", A_STATUS, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);

        // IRQ masking and routing
        reg_op("mask_wr9", A_MASK, 1'b1, 4'hF, 32'h0000_0009, 32'h0, 1'b0);
        reg_op("mask_rd9", A_MASK, 1'b0, 4'hF, 32'h0, 32'h0000_0009, 1'b1);
        s_irq = 4'b1111;
        #1;
        chk("irq_latency", 32'(uirq), 32'd0);
        @(negedge clk);
        chk("irq_9", 32'(uirq), 32'h1);
        reg_op("mask_wr_sel1", A_MASK, 1'b1, 4'h1, 32'h0000_0002, 32'h0, 1'b0);
        reg_op("mask_rd_sel1", A_MASK, 1'b0, 4'hF, 32'h0, 32'h0000_0009, 1'b1);
        chk("irq_sel1", 32'(uirq), 32'h1);
        reg_op("mask_wr6", A_MASK, 1'b1, 4'hF, 32'h0000_0006, 32'h0, 1'b0);
        chk("irq_6", 32'(uirq), 32'h6);

        // Reset while waiting on slave 0
        adr = 32'h3000_0000;
        stb = 1'b1;
        cyc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_stb_pre", 32'(s_stb), 32'h1);
        rst_n = 1'b0;
        s_ack = 4'b0001;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_stb", 32'(s_stb), 32'd0);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_irq", 32'(uirq), 32'd0);
        reg_op("mid_status", A_STATUS, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
        reg_op("mid_mask", A_MASK, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
        reg_op("mid_last", A_LAST, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
        reg_op("rsvd", 32'h300F_000C, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);

        // Normal slave access after the reset
        adr   = 32'h3000_0000;
        stb   = 1'b1;
        cyc   = 1'b1;
        s_ack = 4'b0001;
        #1;
        chk("post_ack", 32'(ack), 32'd1);
        chk("post_dat", rdat, 32'h0BAD_F00D);
        chk("post_stb", 32'(s_stb), 32'h1);
        bus_idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_periph_splitter.md
# wb_periph_splitter

Parametrised Wishbone slave-side splitter that fans the user-project Wishbone port out to `NUM_SLAVES` peripheral instances (UARTs and future peripherals), decoding `wbs_adr_i[19:16]`. It also provides:
- a bus-timeout watchdog;
- error responses for unmapped windows;
- a small local CSR window with error statistics and per-slave IRQ masking;
- routing of masked slave interrupts onto the three `user_irq` lines.

It sits between the top-level Wishbone port and the peripheral instances.

## Interface
- `NUM_SLAVES`, default 4: number of peripheral windows. Legal range 1..15; window index 15 is reserved for local CSRs.
- `TIMEOUT`, default 255: wait cycles before a timeout ack. Legal range 2..65535.
- `wb_clk_i`  in  1  clock.
- `wb_rst_n_i`  in  1  reset. One clock; reset is synchronous and active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone master strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge to master.
- `wbs_dat_o`  out  32  read data. Valid only while `wbs_ack_o`=1.
- `s_stb_o`  out  `NUM_SLAVES`  per-slave strobe. Slaves take adr, dat, we, sel and cyc directly from the master.
- `s_ack_i`  in  `NUM_SLAVES`  per-slave ack.
- `s_dat_i`  in  32*`NUM_SLAVES`  per-slave read data; slave i is at bits [32i+31:32i].
- `s_irq_i`  in  `NUM_SLAVES`  per-slave level interrupt.
- `user_irq`  out  3  routed interrupts.

## Operation
- **Decode.** `idx = wbs_adr_i[19:16]`; `req = wbs_stb_i & wbs_cyc_i`. Each request takes exactly one of three paths.
- **Slave path** (`idx < NUM_SLAVES`):
  - `s_stb_o[idx] = wbs_stb_i & ~abort`; all other `s_stb_o` bits are 0.
  - The slave's ack and data pass combinationally to the master.
- **Unmapped path** (`NUM_SLAVES <= idx < 15`): registered one-cycle error ack, data `0xDEADBEEF`.
- **Local path** (`idx == 15`): registered one-cycle ack. Register is selected by `wbs_adr_i[3:2]`:
  - 0 STATUS (RO): [15:0] `ERR_CNT`, [16] `TO_FLAG`, [31:17] 0. A write of any value clears both fields.
  - 1 IRQ_MASK (RW): [`NUM_SLAVES`-1:0] mask, upper bits read 0. Reset value 0.
  - 2 LAST_ERR_ADR (RO): full `wbs_adr_i` of the most recent unmapped or timed-out request.
  - 3 reads 0, writes ignored.
  - Writes take effect only when `wbs_sel_i == 4'hF`; other sel values are acked and ignored.
- **FSM states:**
  - IDLE → WAIT on `req` with slave `idx`.
  - IDLE → RESP on `req` with unmapped or local `idx`.
  - WAIT → IDLE on `s_ack_i[idx]`, or on `req` falling (master abandons).
  - WAIT → TOUT when the wait counter equals `TIMEOUT`.
  - RESP → IDLE after one cycle; ack is high during RESP.
  - TOUT → DRAIN after one cycle; ack is high with data `0xBADC0FFE`, `abort`=1, and `TO_FLAG` is set.
  - DRAIN → IDLE when `wbs_stb_i`=0; `abort` stays 1 throughout DRAIN.
- **Wait counter:**
  - Cleared in IDLE.
  - Increments each WAIT cycle without a slave ack.
  - Width is clog2(`TIMEOUT`+1).
- **Error recording:** each unmapped or timeout event increments `ERR_CNT` (16-bit, saturates at `0xFFFF`) and updates LAST_ERR_ADR. An error event in the same cycle as a STATUS clear write cannot occur, because the block is single-outstanding.
- **IRQ routing:**
  - `user_irq[k]` is the registered OR of `(s_irq_i[i] & mask[i])` over all `i` with `i % 3 == k`.
  - Latency is one cycle.

## Timing
- **Reset** (`wb_rst_n_i`=0 at an edge):
  - FSM → IDLE; counter, `ERR_CNT`, `TO_FLAG`, LAST_ERR_ADR and IRQ_MASK → 0.
  - `user_irq` = 0 and `abort` = 0.
  - While reset is held: `s_stb_o` = 0, and `wbs_ack_o` = 0 from the block itself.
  - Reset mid-transaction drops the in-flight request with no ack.
- **Slave access:** zero added latency; the master sees an ack in the same cycle the slave acks.
- **Unmapped/local access:** `req` is sampled at edge N; ack is high during cycle N+1 only.
  - Back-to-back requests need `req` low for one cycle, or the master re-asserts after the ack.
  - No double ack: RESP always returns to IDLE.
- **Timeout:**
  - `req` first high in cycle 0 with a silent slave: ack is asserted in cycle `TIMEOUT`+1.
  - `s_stb_o` is low from that cycle until `wbs_stb_i` drops.
- **Simultaneous events:**
  - A slave ack in the cycle the counter reaches `TIMEOUT` wins: normal ack, no error recorded.
  - A slave ack arriving during DRAIN is not forwarded.
- **Data rules:**
  - `wbs_dat_o` uses the slave mux in the slave path and the response register otherwise.
  - Do not depend on `wbs_dat_o` outside an ack.

## Test plan
- **Slave path:** read `0x3001_0004` while slave 1 acks in the same cycle with `0x12345678` → `wbs_ack_o`=1 that cycle, `wbs_dat_o`=`0x12345678`, only `s_stb_o[1]` high.
- **Unmapped read:** read `idx`=7 with `NUM_SLAVES`=4 → ack one cycle later, data `0xDEADBEEF`. Then STATUS reads `0x0000_0001` and LAST_ERR_ADR = `0x3007_0000`.
- **Timeout:** `TIMEOUT`=8, slave 2 never acks → ack in cycle 9 with `0xBADC0FFE` and `s_stb_o[2]` low afterwards. STATUS = `0x0001_0001`. A subsequent write to STATUS clears it to 0.
- **Ack at timeout boundary:** slave acks exactly in the cycle the counter reaches `TIMEOUT` → normal data returned, `ERR_CNT` unchanged.
- **IRQ routing:** write IRQ_MASK=`0x9` with `sel`=`0xF`, then raise `s_irq_i`=`4'b1111` → `user_irq`=`3'b001` one cycle later. A mask write with `sel`=`0x1` leaves the mask unchanged.
- **Reset mid-transaction:** assert `wb_rst_n_i`=0 in WAIT → no ack, `s_stb_o`=0, all CSRs read 0 after release, next access completes normally.
